// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NRD bypassed read ports,
// and a one-entry-per-cycle clear sweep after reset or on request.
module regfile_mp #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              ready,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [DW-1:0]   mem [DEPTH];
    logic            wr0_en;
    logic            wr1_en;
    logic [AW-1:0]   a;
    logic [DW-1:0]   v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign wr0_en = (state == RUN) && !clr && we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign wr1_en = (state == RUN) && !clr && we1 && !((ZERO_REG != 0) && (wa1 == '0));

    // Storage has no reset; while rst is high the state is already CLEAR, so the
    // only write that can land is a zero into entry cnt, which the sweep redoes anyway.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (wr0_en) mem[wa0] <= wd0;
            if (wr1_en) mem[wa1] <= wd1;
        end
    end

    always_comb begin
        rd = '0;
        a  = '0;
        v  = '0;
        if (state == RUN) begin
            for (int unsigned k = 0; k < NRD; k++) begin
                a = ra[k*AW +: AW];
                v = mem[a];
                if (we0 && (wa0 == a)) v = wd0;
                if (we1 && (wa1 == a)) v = wd1;
                if ((ZERO_REG != 0) && (a == '0)) v = '0;
                rd[k*DW +: DW] = v;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              ready;
    logic              we0;
    logic [AW-1:0]     wa0;
    logic [DW-1:0]     wd0;
    logic              we1;
    logic [AW-1:0]     wa1;
    logic [DW-1:0]     wd1;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] rd;

    typedef struct {
        string       name;
        int          kind;   // 0 = rd lane, 1 = ready
        int          lane;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;

    regfile_mp #(.DW(DW), .DEPTH(32), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            if (e.kind == 1) act = {31'b0, ready};
            else             act = rd[e.lane*DW +: DW];
            tests++;
            if (act !== e.exp) begin
                failed++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rd(input string name, input int lane, input logic [31:0] val);
        exp_t e;
        e.name = name; e.kind = 0; e.lane = lane; e.exp = val;
        q.push_back(e);
    endtask

    task automatic exp_rdy(input string name, input logic val);
        exp_t e;
        e.name = name; e.kind = 1; e.lane = 0; e.exp = {31'b0, val};
        q.push_back(e);
    endtask

    task automatic set_ra(input int a0, input int a1);
        ra[0 +: AW]  = AW'(a0);
        ra[AW +: AW] = AW'(a1);
    endtask

    task automatic count_sweep(input string name, input int wr4_from);
        for (int e = 1; e <= 32; e++) begin
            cyc();
            we0 = (wr4_from > 0) && (e >= wr4_from) && (e < 32);
            wa0 = 5'd4;
            wd0 = 32'h0000_00AA;
            exp_rdy(name, e == 32);
            if (e < 32) exp_rd({name, "_rd"}, 0, 32'h0);
        end
        we0 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        ra  = '0;
        set_ra(3, 9);
        exp_rdy("rst_ready", 1'b0);
        exp_rd("rst_rd0", 0, 32'h0);
        exp_rd("rst_rd1", 1, 32'h0);
        repeat (2) cyc();
        rst = 1'b0;

        count_sweep("sweep1", 0);

        for (int i = 0; i < 32; i++) begin
            cyc();
            set_ra(i, 31 - i);
            exp_rd("post_sweep_l0", 0, 32'h0);
            exp_rd("post_sweep_l1", 1, 32'h0);
        end

        cyc();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
        set_ra(5, 6);
        exp_rd("wr_bypass", 0, 32'hDEAD_BEEF);
        exp_rd("wr_other", 1, 32'h0);
        cyc();
        we0 = 1'b0;
        exp_rd("wr_stored", 0, 32'hDEAD_BEEF);
        exp_rd("wr_other2", 1, 32'h0);

        cyc();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        set_ra(7, 7);
        exp_rd("prio_byp_l0", 0, 32'h22);
        exp_rd("prio_byp_l1", 1, 32'h22);
        cyc();
        we0 = 1'b0; we1 = 1'b0;
        exp_rd("prio_stored", 0, 32'h22);

        cyc();
        we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h33;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h44;
        set_ra(8, 9);
        exp_rd("dual_byp0", 0, 32'h33);
        exp_rd("dual_byp1", 1, 32'h44);
        cyc();
        we0 = 1'b0; we1 = 1'b0;
        exp_rd("dual_st0", 0, 32'h33);
        exp_rd("dual_st1", 1, 32'h44);

        cyc();
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
        set_ra(0, 5);
        exp_rd("zero_byp", 0, 32'h0);
        exp_rd("zero_other", 1, 32'hDEAD_BEEF);
        cyc();
        we1 = 1'b0;
        exp_rd("zero_stored", 0, 32'h0);

        for (int i = 1; i < 32; i++) begin
            cyc();
            we0 = 1'b1; wa0 = AW'(i); wd0 = 32'(i);
        end
        cyc();
        we0 = 1'b0;
        set_ra(3, 31);
        exp_rd("fill3", 0, 32'd3);
        exp_rd("fill31", 1, 32'd31);

        cyc();
        clr = 1'b1;
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h55;
        exp_rd("clr_cycle_byp", 0, 32'h55);
        exp_rdy("clr_cycle_ready", 1'b1);
        cyc();
        clr = 1'b0; we0 = 1'b0;
        exp_rdy("clr_ready0", 1'b0);
        exp_rd("clr_rd0", 0, 32'h0);
        exp_rd("clr_rd1", 1, 32'h0);
        count_sweep("sweep2", 0);
        cyc();
        set_ra(3, 31);
        exp_rd("clr_discard3", 0, 32'h0);
        exp_rd("clr_cleared31", 1, 32'h0);

        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        for (int j = 1; j <= 10; j++) cyc();
        #1;
        rst = 1'b1;
        exp_rdy("rst_mid_sweep", 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        set_ra(4, 4);
        count_sweep("sweep3", 8);
        cyc();
        set_ra(4, 10);
        exp_rd("clear_wr_ignored", 0, 32'h0);
        exp_rd("restart_cleared10", 1, 32'h0);
        exp_rdy("sweep3_done", 1'b1);

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected finish before 50000");
        $fatal(1);
    end

endmodule
